// File: rtl/tdm_mpram_if.sv
// Port bundle for tdm_mpram: flattened per-port address/data/request lanes
// plus the slot strobe, returned read data and return-valid pulses.
interface tdm_mpram_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
   logic [NUM_PORTS-1:0]            port_we;
   logic [NUM_PORTS-1:0]            port_strobe;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_rdata;
   logic [NUM_PORTS-1:0]            port_valid;

   modport master (
      output port_addr, port_wdata, port_we,
      input  port_strobe, port_rdata, port_valid
   );

   modport slave (
      input  port_addr, port_wdata, port_we,
      output port_strobe, port_rdata, port_valid
   );
endinterface

// File: rtl/tdm_mpram.sv
// N-port time-division-multiplexed RAM on a single-port synchronous array.
// Optional macro TDM_MPRAM_WRITE_FWD_EN selects write-through return data (default read-first).
module tdm_mpram #(
   parameter int                   NUM_PORTS   = 4,
   parameter int                   ADDR_WIDTH  = 16,
   parameter int                   DATA_WIDTH  = 8,
   parameter logic [NUM_PORTS-1:0] WRITE_PORTS = NUM_PORTS'(1)
) (
   input logic        clk,
   input logic        reset,
   tdm_mpram_if.slave bus
);
   localparam int             IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [IW-1:0]  LAST_SLOT = IW'(NUM_PORTS - 1);

   logic [IW-1:0]                   slot_q, slot_d;
   logic [NUM_PORTS-1:0]            strobe_s;
   logic                            s1_valid_q, s1_valid_d;
   logic [IW-1:0]                   s1_idx_q, s1_idx_d;
   logic [ADDR_WIDTH-1:0]           s1_addr_q, s1_addr_d;
   logic [DATA_WIDTH-1:0]           s1_wdata_q, s1_wdata_d;
   logic                            s1_we_q, s1_we_d;
   logic                            s2_valid_q, s2_valid_d;
   logic [IW-1:0]                   s2_idx_q, s2_idx_d;
   logic [DATA_WIDTH-1:0]           rd_data_q;
   logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]            valid_q, valid_d;
   logic [DATA_WIDTH-1:0]           mem_array [2**ADDR_WIDTH];

   // Slot rotation, strobe decode and stage-1 capture of the owning port's lanes
   always_comb begin
      strobe_s = '0;
      if (!reset) begin
         strobe_s[slot_q] = 1'b1;
      end else begin
         strobe_s = '0;
      end
      if (slot_q == LAST_SLOT) begin
         slot_d = '0;
      end else begin
         slot_d = slot_q + IW'(1);
      end
      s1_valid_d = 1'b1;
      s1_idx_d   = slot_q;
      s1_addr_d  = bus.port_addr[int'(slot_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s1_wdata_d = bus.port_wdata[int'(slot_q)*DATA_WIDTH +: DATA_WIDTH];
      s1_we_d    = bus.port_we[slot_q] & WRITE_PORTS[slot_q];
      s2_valid_d = s1_valid_q;
      s2_idx_d   = s1_idx_q;
   end

   // Return stage: steer the array output to the owning port, others hold
   always_comb begin
      rdata_d = rdata_q;
      valid_d = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (s2_valid_q && (s2_idx_q == IW'(i))) begin
            rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
            valid_d[i]                          = 1'b1;
         end else begin
            rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata_q[i*DATA_WIDTH +: DATA_WIDTH];
            valid_d[i]                          = 1'b0;
         end
      end
   end

   // Pipeline and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_idx_q   <= '0;
         s1_addr_q  <= '0;
         s1_wdata_q <= '0;
         s1_we_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_idx_q   <= '0;
         rdata_q    <= '0;
         valid_q    <= '0;
      end else begin
         slot_q     <= slot_d;
         s1_valid_q <= s1_valid_d;
         s1_idx_q   <= s1_idx_d;
         s1_addr_q  <= s1_addr_d;
         s1_wdata_q <= s1_wdata_d;
         s1_we_q    <= s1_we_d;
         s2_valid_q <= s2_valid_d;
         s2_idx_q   <= s2_idx_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
      end
   end

   // Single-port array; a write still in stage 1 when reset hits is dropped
   always_ff @(posedge clk) begin
      if (s1_valid_q && s1_we_q && !reset) begin
         mem_array[s1_addr_q] <= s1_wdata_q;
      end
`ifdef TDM_MPRAM_WRITE_FWD_EN
      rd_data_q <= s1_we_q ? s1_wdata_q : mem_array[s1_addr_q];
`else
      rd_data_q <= mem_array[s1_addr_q];
`endif
   end

   assign bus.port_strobe = strobe_s;
   assign bus.port_rdata  = rdata_q;
   assign bus.port_valid  = valid_q;
endmodule

// File: tb/tb_tdm_mpram.sv
// Directed self-checking bench for tdm_mpram: 4-port main instance plus
// 3-port and 1-port instances for slot wrap and single-port behaviour.
module tb_tdm_mpram;
   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

`ifdef TDM_MPRAM_WRITE_FWD_EN
   localparam logic [7:0] T3_WR_EXP = 8'h3C;
`else
   localparam logic [7:0] T3_WR_EXP = 8'hA5;
`endif

   tdm_mpram_if #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8)) bus4 ();
   tdm_mpram_if #(.NUM_PORTS(3), .ADDR_WIDTH(8),  .DATA_WIDTH(8)) bus3 ();
   tdm_mpram_if #(.NUM_PORTS(1), .ADDR_WIDTH(8),  .DATA_WIDTH(8)) bus1 ();

   tdm_mpram #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(8), .WRITE_PORTS(4'b0001))
      u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
   tdm_mpram #(.NUM_PORTS(3), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WRITE_PORTS(3'b111))
      u_dut3 (.clk(clk), .reset(reset), .bus(bus3));
   tdm_mpram #(.NUM_PORTS(1), .ADDR_WIDTH(8), .DATA_WIDTH(8), .WRITE_PORTS(1'b1))
      u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access on the 4-port instance; waits for the port's slot.
   task automatic acc4(input int p, input logic [15:0] a, input logic [7:0] wd,
                       input logic we, input bit chk_data, input logic [7:0] exp,
                       input string tag);
      int n = 0;
      while (bus4.port_strobe[p] !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      chk({tag, "_slot"}, 32'(bus4.port_strobe[p]), 32'd1);
      bus4.port_addr[p*16 +: 16] = a;
      bus4.port_wdata[p*8 +: 8]  = wd;
      bus4.port_we[p]            = we;
      step();
      bus4.port_we = 4'b0000;
      step();
      chk({tag, "_early"}, 32'(bus4.port_valid[p]), 32'd0);
      step();
      chk({tag, "_valid"}, 32'(bus4.port_valid), 32'(4'b0001 << p));
      if (chk_data) chk({tag, "_rdata"}, 32'(bus4.port_rdata[p*8 +: 8]), 32'(exp));
   endtask

   // One access on the 3-port instance.
   task automatic acc3(input int p, input logic [7:0] a, input logic [7:0] wd,
                       input logic we, input bit chk_data, input logic [7:0] exp,
                       input string tag);
      int n = 0;
      while (bus3.port_strobe[p] !== 1'b1 && n < 12) begin
         step();
         n++;
      end
      chk({tag, "_slot"}, 32'(bus3.port_strobe[p]), 32'd1);
      bus3.port_addr[p*8 +: 8]  = a;
      bus3.port_wdata[p*8 +: 8] = wd;
      bus3.port_we[p]           = we;
      step();
      bus3.port_we = 3'b000;
      step();
      step();
      chk({tag, "_valid"}, 32'(bus3.port_valid), 32'(3'b001 << p));
      if (chk_data) chk({tag, "_rdata"}, 32'(bus3.port_rdata[p*8 +: 8]), 32'(exp));
   endtask

   logic [3:0] exp4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [2:0] exp3 [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

   initial begin
      reset = 1'b1;
      bus4.port_addr = '0; bus4.port_wdata = '0; bus4.port_we = '0;
      bus3.port_addr = '0; bus3.port_wdata = '0; bus3.port_we = '0;
      bus1.port_addr = '0; bus1.port_wdata = '0; bus1.port_we = '0;

      // 1. Reset state then strobe rotation
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_strobe", 32'(bus4.port_strobe), 32'd0);
         chk("rst_valid", 32'(bus4.port_valid), 32'd0);
         chk("rst_rdata", bus4.port_rdata, 32'd0);
      end
      chk("rst_strobe3", 32'(bus3.port_strobe), 32'd0);
      chk("rst_strobe1", 32'(bus1.port_strobe), 32'd0);
      reset = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         chk("rot_strobe4", 32'(bus4.port_strobe), 32'(exp4[i]));
         chk("rot_strobe3", 32'(bus3.port_strobe), 32'(exp3[i]));
         chk("rot_strobe1", 32'(bus1.port_strobe), 32'd1);
      end

      // 2. Port0 write, port2 read-back
      acc4(0, 16'h1234, 8'hA5, 1'b1, 1'b0, 8'h00, "t2_wr");
      acc4(2, 16'h1234, 8'h00, 1'b0, 1'b1, 8'hA5, "t2_rd");

      // 3. Overwrite: read-first vs write-through return data
      acc4(0, 16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00, "t3_init");
      acc4(0, 16'h0010, 8'h3C, 1'b1, 1'b1, T3_WR_EXP, "t3_wr");
      acc4(3, 16'h0010, 8'h00, 1'b0, 1'b1, 8'h3C, "t3_rd");

      // 4. Read-only port request to write is a read
      acc4(1, 16'h0010, 8'hFF, 1'b1, 1'b1, 8'h3C, "t4_ro");
      acc4(0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'h3C, "t4_rd");

      // 5. Reset at E1 drops a captured write
      acc4(0, 16'h0020, 8'h11, 1'b1, 1'b0, 8'h00, "t5_pre");
      for (int n = 0; n < 8 && bus4.port_strobe[0] !== 1'b1; n++) step();
      chk("t5_slot", 32'(bus4.port_strobe[0]), 32'd1);
      bus4.port_addr[15:0] = 16'h0020;
      bus4.port_wdata[7:0] = 8'h77;
      bus4.port_we[0]      = 1'b1;
      step();
      bus4.port_we = 4'b0000;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_valid", 32'(bus4.port_valid), 32'd0);
         chk("t5_strobe", 32'(bus4.port_strobe), 32'd0);
      end
      chk("t5_rdata", bus4.port_rdata, 32'd0);
      reset = 1'b0;
      #1;
      chk("t5_rel_strobe", 32'(bus4.port_strobe), 32'd1);
      acc4(0, 16'h0020, 8'h00, 1'b0, 1'b1, 8'h11, "t5_rd");

      // 6a. Three-port build: every port writes, a different port reads back
      acc3(0, 8'h40, 8'h61, 1'b1, 1'b0, 8'h00, "t6_w0");
      acc3(1, 8'h41, 8'h62, 1'b1, 1'b0, 8'h00, "t6_w1");
      acc3(2, 8'h42, 8'h63, 1'b1, 1'b0, 8'h00, "t6_w2");
      acc3(1, 8'h40, 8'h00, 1'b0, 1'b1, 8'h61, "t6_r1");
      acc3(2, 8'h41, 8'h00, 1'b0, 1'b1, 8'h62, "t6_r2");
      acc3(0, 8'h42, 8'h00, 1'b0, 1'b1, 8'h63, "t6_r0");

      // 6b. Single-port build: back-to-back write then read
      bus1.port_addr  = 8'h55;
      bus1.port_wdata = 8'h9C;
      bus1.port_we    = 1'b1;
      step();
      bus1.port_we = 1'b0;
      step();
      step();
      chk("t6_p1_wvalid", 32'(bus1.port_valid), 32'd1);
      step();
      chk("t6_p1_rvalid", 32'(bus1.port_valid), 32'd1);
      chk("t6_p1_rdata", 32'(bus1.port_rdata), 32'h9C);
      chk("t6_p1_strobe", 32'(bus1.port_strobe), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
